vip_rgb565_gray_meas: RTL and testbench

Downstream consumer of the CMOS RGB565 capture stage. Takes the clken-qualified RGB565 pixel stream with its vsync/href and converts each pixel to 8-bit luminance (gray) in a fixed-latency pipeline, re-timing the sync signals to match. It also measures the active frame geometry (pixels per line, lines per frame) and flags inconsistent line widths, for use by downstream gray-domain VIP stages and by debug/status registers.

---
 rtl/vip_rgb565_gray_meas_if.sv | 21 ++
 rtl/vip_rgb565_gray_meas.sv | 152 +++++++++++++++
 tb/tb_vip_rgb565_gray_meas.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vip_rgb565_gray_meas_if.sv
// Video stream bundle around the gray converter: RGB565 input side (per_*) and gray output side (post_*).
interface vip_rgb565_gray_meas_if;
  logic        per_frame_vsync;
  logic        per_frame_href;
  logic        per_frame_clken;
  logic [15:0] per_frame_data;
  logic        post_frame_vsync;
  logic        post_frame_href;
  logic        post_frame_clken;
  logic [7:0]  post_img_gray;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken, per_frame_data,
    input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_gray
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken, per_frame_data,
    output post_frame_vsync, post_frame_href, post_frame_clken, post_img_gray
  );
endinterface

// File: rtl/vip_rgb565_gray_meas.sv
// RGB565 -> 8-bit luma in a 3-clk pipeline, plus frame width/height measurement on the input side.
// Define GRAY_ROUND_EN for round-to-nearest luma; default build truncates.
module vip_rgb565_gray_meas #(
  parameter int CNT_W  = 12,
  parameter int COEF_R = 77,
  parameter int COEF_G = 150,
  parameter int COEF_B = 29
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vip_rgb565_gray_meas_if.slave vid,
  output logic [CNT_W-1:0]     frame_width,
  output logic [CNT_W-1:0]     frame_height,
  output logic                 frame_size_valid,
  output logic                 line_width_err
);

  localparam logic [7:0]       CR      = 8'(COEF_R);
  localparam logic [7:0]       CG      = 8'(COEF_G);
  localparam logic [7:0]       CB      = 8'(COEF_B);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [7:0]  r8_q, g8_q, b8_q;
  logic [15:0] pr_q, pg_q, pb_q;
  logic [15:0] sum;
  logic [7:0]  gray_q;
  logic [2:0]  vs_pipe_q, hs_pipe_q, ce_pipe_q;

  always_comb begin
    sum = pr_q + pg_q + pb_q;
`ifdef GRAY_ROUND_EN
    sum = sum + 16'd128;
`endif
  end

  // Data path and sync chain advance together every clock; hs_pipe_q[1] is the href
  // that lands on the output alongside the stage-3 result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r8_q      <= '0;
      g8_q      <= '0;
      b8_q      <= '0;
      pr_q      <= '0;
      pg_q      <= '0;
      pb_q      <= '0;
      gray_q    <= '0;
      vs_pipe_q <= '0;
      hs_pipe_q <= '0;
      ce_pipe_q <= '0;
    end else begin
      r8_q      <= {vid.per_frame_data[15:11], vid.per_frame_data[15:13]};
      g8_q      <= {vid.per_frame_data[10:5],  vid.per_frame_data[10:9]};
      b8_q      <= {vid.per_frame_data[4:0],   vid.per_frame_data[4:2]};
      pr_q      <= {8'd0, r8_q} * {8'd0, CR};
      pg_q      <= {8'd0, g8_q} * {8'd0, CG};
      pb_q      <= {8'd0, b8_q} * {8'd0, CB};
      gray_q    <= hs_pipe_q[1] ? sum[15:8] : 8'd0;
      vs_pipe_q <= {vs_pipe_q[1:0], vid.per_frame_vsync};
      hs_pipe_q <= {hs_pipe_q[1:0], vid.per_frame_href};
      ce_pipe_q <= {ce_pipe_q[1:0], vid.per_frame_clken};
    end
  end

  assign vid.post_frame_vsync = vs_pipe_q[2];
  assign vid.post_frame_href  = hs_pipe_q[2];
  assign vid.post_frame_clken = ce_pipe_q[2];
  assign vid.post_img_gray    = gray_q;

  logic             vs_q, hs_q;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0] first_w_q, first_w_d;
  logic             err_acc_q, err_acc_d;
  logic [CNT_W-1:0] frame_width_q, frame_width_d;
  logic [CNT_W-1:0] frame_height_q, frame_height_d;
  logic             size_valid_q, size_valid_d;
  logic             width_err_q, width_err_d;
  logic             href_fall, vs_fall, vs_rise;

  always_comb begin
    href_fall      = hs_q & ~vid.per_frame_href;
    vs_fall        = vs_q & ~vid.per_frame_vsync;
    vs_rise        = ~vs_q & vid.per_frame_vsync;
    pix_cnt_d      = pix_cnt_q;
    line_cnt_d     = line_cnt_q;
    first_w_d      = first_w_q;
    err_acc_d      = err_acc_q;
    frame_width_d  = frame_width_q;
    frame_height_d = frame_height_q;
    size_valid_d   = size_valid_q;
    width_err_d    = width_err_q;

    if (href_fall) begin
      pix_cnt_d = '0;
      if (line_cnt_q == '0)
        first_w_d = pix_cnt_q;
      else if (pix_cnt_q != first_w_q)
        err_acc_d = 1'b1;
      if (line_cnt_q != CNT_MAX)
        line_cnt_d = line_cnt_q + CNT_ONE;
    end else if (vid.per_frame_href && vid.per_frame_clken && pix_cnt_q != CNT_MAX) begin
      pix_cnt_d = pix_cnt_q + CNT_ONE;
    end

    // Latch from the _d values so a line ending on the same clock as the frame is included.
    if (vs_fall) begin
      frame_width_d  = first_w_d;
      frame_height_d = line_cnt_d;
      width_err_d    = err_acc_d;
      size_valid_d   = 1'b1;
    end

    if (vs_rise) begin
      line_cnt_d = '0;
      err_acc_d  = 1'b0;
      first_w_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q           <= 1'b0;
      hs_q           <= 1'b0;
      pix_cnt_q      <= '0;
      line_cnt_q     <= '0;
      first_w_q      <= '0;
      err_acc_q      <= 1'b0;
      frame_width_q  <= '0;
      frame_height_q <= '0;
      size_valid_q   <= 1'b0;
      width_err_q    <= 1'b0;
    end else begin
      vs_q           <= vid.per_frame_vsync;
      hs_q           <= vid.per_frame_href;
      pix_cnt_q      <= pix_cnt_d;
      line_cnt_q     <= line_cnt_d;
      first_w_q      <= first_w_d;
      err_acc_q      <= err_acc_d;
      frame_width_q  <= frame_width_d;
      frame_height_q <= frame_height_d;
      size_valid_q   <= size_valid_d;
      width_err_q    <= width_err_d;
    end
  end

  assign frame_width      = frame_width_q;
  assign frame_height     = frame_height_q;
  assign frame_size_valid = size_valid_q;
  assign line_width_err   = width_err_q;

endmodule

// File: tb/tb_vip_rgb565_gray_meas.sv
// Randomised self-checking bench for vip_rgb565_gray_meas against a plain-arithmetic luma/geometry model.
module tb_vip_rgb565_gray_meas;
  localparam int CNT_W = 12;
  localparam int MAXV  = 4095;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  vip_rgb565_gray_meas_if vif();
  logic [CNT_W-1:0] frame_width, frame_height;
  logic             frame_size_valid, line_width_err;

  int n_chk  = 0;
  int n_pass = 0;
  int line_w[$];

  always #5 clk = ~clk;

  vip_rgb565_gray_meas #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .vid              (vif),
    .frame_width      (frame_width),
    .frame_height     (frame_height),
    .frame_size_valid (frame_size_valid),
    .line_width_err   (line_width_err)
  );

  // Luma as weighted sum of 8-bit channels widened by bit replication.
  function automatic int ref_gray(input logic [15:0] d, input logic h);
    int r, g, b, s;
    r = int'(d[15:11]);
    g = int'(d[10:5]);
    b = int'(d[4:0]);
    r = r * 8 + r / 4;
    g = g * 4 + g / 16;
    b = b * 8 + b / 4;
    s = r * 77 + g * 150 + b * 29;
`ifdef GRAY_ROUND_EN
    s = s + 128;
`endif
    return h ? s / 256 : 0;
  endfunction

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  // Geometry the frame described by line_w should produce.
  function automatic void exp_meas(output int w, output int h, output bit e);
    w = sat(line_w[0]);
    h = sat(line_w.size());
    e = 1'b0;
    foreach (line_w[k]) if (sat(line_w[k]) != w) e = 1'b1;
  endfunction

  task automatic step(input logic v, input logic h, input logic c, input logic [15:0] d);
    vif.per_frame_vsync = v;
    vif.per_frame_href  = h;
    vif.per_frame_clken = c;
    vif.per_frame_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int gap, input bit same_edge);
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    for (int l = 0; l < line_w.size(); l++) begin
      if (line_w[l] == 0) step(1, 1, 0, 16'($urandom));
      for (int p = 0; p < line_w[l]; p++) begin
        step(1, 1, 1, 16'($urandom));
        for (int g = 1; g < gap; g++) step(1, 1, 0, 16'($urandom));
      end
      if (same_edge && l == line_w.size() - 1) break;
      step(1, 0, 0, 16'h0);
      step(1, 0, 0, 16'h0);
    end
    repeat (4) step(0, 0, 0, 16'h0);
  endtask

  task automatic test_reset();
    logic [36:0] outs;
    vif.per_frame_vsync = 1'b1;
    vif.per_frame_href  = 1'b1;
    vif.per_frame_clken = 1'b1;
    vif.per_frame_data  = 16'hFFFF;
    repeat (4) @(posedge clk);
    #1;
    outs = {vif.post_frame_vsync, vif.post_frame_href, vif.post_frame_clken, vif.post_img_gray,
            frame_width, frame_height, frame_size_valid, line_width_err};
    n_chk++;
    if (outs !== '0) $display("FAIL reset_initial: got %h expected 0", outs); else n_pass++;
    rst_n = 1'b1;
    line_w = '{2, 2};
    send_frame(1, 0);
    n_chk++;
    if (frame_size_valid !== 1'b1) $display("FAIL reset_prime_valid: got %b expected 1", frame_size_valid);
    else n_pass++;
    // Mid-frame asynchronous reset with live inputs.
    step(1, 0, 0, 16'h0);
    repeat (5) step(1, 1, 1, 16'hFFFF);
    #2 rst_n = 1'b0;
    #1;
    outs = {vif.post_frame_vsync, vif.post_frame_href, vif.post_frame_clken, vif.post_img_gray,
            frame_width, frame_height, frame_size_valid, line_width_err};
    n_chk++;
    if (outs !== '0) $display("FAIL reset_async: got %h expected 0", outs); else n_pass++;
    repeat (3) step(1, 1, 1, 16'hFFFF);
    outs = {vif.post_frame_vsync, vif.post_frame_href, vif.post_frame_clken, vif.post_img_gray,
            frame_width, frame_height, frame_size_valid, line_width_err};
    n_chk++;
    if (outs !== '0) $display("FAIL reset_held: got %h expected 0", outs); else n_pass++;
    rst_n = 1'b1;
    // Partial frame picked up after release: 4 pixels, one line.
    repeat (4) step(1, 1, 1, 16'h1234);
    step(1, 0, 0, 16'h0);
    repeat (3) step(0, 0, 0, 16'h0);
    n_chk++;
    if ({frame_width, frame_height, frame_size_valid, line_width_err} !== {12'd4, 12'd1, 1'b1, 1'b0})
      $display("FAIL reset_partial_frame: got w=%0d h=%0d v=%b e=%b expected w=4 h=1 v=1 e=0",
               frame_width, frame_height, frame_size_valid, line_width_err);
    else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_colours();
    logic [15:0] pix [5];
    int          exp_g [5];
    pix = '{16'hFFFF, 16'h0000, 16'hF800, 16'h07E0, 16'h001F};
`ifdef GRAY_ROUND_EN
    exp_g = '{255, 0, 77, 149, 29};
`else
    exp_g = '{255, 0, 76, 149, 28};
`endif
    for (int j = 0; j < 7; j++) begin
      step(1, 1, j < 5, (j < 5) ? pix[j] : 16'h0);
      if (j >= 2) begin
        n_chk++;
        if (int'(vif.post_img_gray) !== exp_g[j-2])
          $display("FAIL colour_%h: got %0d expected %0d", pix[j-2], vif.post_img_gray, exp_g[j-2]);
        else n_pass++;
      end
    end
    $display("test_colours done");
  endtask

  task automatic test_pixels();
    logic [10:0] expq[$];
    logic [10:0] e, got;
    logic        v, h, c;
    logic [15:0] d;
    for (int j = 0; j < 300; j++) begin
      v = 1'($urandom);
      h = 1'($urandom);
      c = 1'($urandom);
      d = 16'($urandom);
      expq.push_back({v, h, c, 8'(ref_gray(d, h))});
      step(v, h, c, d);
      if (expq.size() == 3) begin
        e   = expq.pop_front();
        got = {vif.post_frame_vsync, vif.post_frame_href, vif.post_frame_clken, vif.post_img_gray};
        n_chk++;
        if (got[10:8] !== e[10:8]) $display("FAIL pix_sync: got %b expected %b", got[10:8], e[10:8]);
        else n_pass++;
        n_chk++;
        if (got[7:0] !== e[7:0]) $display("FAIL pix_gray: got %0d expected %0d", got[7:0], e[7:0]);
        else n_pass++;
      end
    end
    $display("test_pixels done: 298 cycles compared");
  endtask

  task automatic check_frame(input string name);
    int w, h;
    bit e;
    exp_meas(w, h, e);
    n_chk++;
    if ({frame_width, frame_height, frame_size_valid, line_width_err} !==
        {CNT_W'(w), CNT_W'(h), 1'b1, e})
      $display("FAIL %s: got w=%0d h=%0d v=%b e=%b expected w=%0d h=%0d v=1 e=%b",
               name, frame_width, frame_height, frame_size_valid, line_width_err, w, h, e);
    else n_pass++;
    $display("%s: frame w=%0d h=%0d err=%b", name, frame_width, frame_height, line_width_err);
  endtask

  task automatic test_full_frame();
    line_w.delete();
    repeat (32) line_w.push_back(640);
    send_frame(2, 0);
    n_chk++;
    if ({frame_width, frame_height, line_width_err} !== {12'd640, 12'd32, 1'b0})
      $display("FAIL full_frame: got w=%0d h=%0d e=%b expected w=640 h=32 e=0",
               frame_width, frame_height, line_width_err);
    else n_pass++;
    $display("test_full_frame done");
  endtask

  task automatic test_line_err();
    line_w.delete();
    repeat (120) line_w.push_back(16);
    line_w[100] = 15;
    send_frame(1, 0);
    n_chk++;
    if ({frame_width, frame_height, line_width_err} !== {12'd16, 12'd120, 1'b1})
      $display("FAIL line_err_set: got w=%0d h=%0d e=%b expected w=16 h=120 e=1",
               frame_width, frame_height, line_width_err);
    else n_pass++;
    line_w[100] = 16;
    send_frame(1, 0);
    n_chk++;
    if (line_width_err !== 1'b0) $display("FAIL line_err_clear: got %b expected 0", line_width_err);
    else n_pass++;
    $display("test_line_err done");
  endtask

  task automatic test_status_stable();
    step(0, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    repeat (3) step(1, 1, 1, 16'($urandom));
    step(1, 0, 0, 16'h0);
    n_chk++;
    if ({frame_width, frame_height, line_width_err} !== {12'd16, 12'd120, 1'b0})
      $display("FAIL status_midframe: got w=%0d h=%0d e=%b expected w=16 h=120 e=0",
               frame_width, frame_height, line_width_err);
    else n_pass++;
    repeat (2) step(1, 1, 1, 16'($urandom));
    step(1, 0, 0, 16'h0);
    repeat (2) step(0, 0, 0, 16'h0);
    n_chk++;
    if ({frame_width, frame_height, line_width_err} !== {12'd3, 12'd2, 1'b1})
      $display("FAIL status_endframe: got w=%0d h=%0d e=%b expected w=3 h=2 e=1",
               frame_width, frame_height, line_width_err);
    else n_pass++;
    $display("test_status_stable done");
  endtask

  task automatic test_same_edge();
    line_w = '{4, 4, 4};
    send_frame(1, 1);
    check_frame("same_edge");
    line_w = '{4, 4, 5};
    send_frame(1, 1);
    check_frame("same_edge_err");
  endtask

  task automatic test_saturate();
    line_w = '{5000, 5000};
    send_frame(1, 0);
    check_frame("saturate");
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 6; f++) begin
      int nl, base, gap;
      bit same;
      nl   = $urandom_range(1, 12);
      base = $urandom_range(0, 30);
      gap  = $urandom_range(1, 3);
      same = 1'($urandom);
      line_w.delete();
      for (int l = 0; l < nl; l++)
        line_w.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : base);
      send_frame(gap, same);
      check_frame("random_frame");
    end
  endtask

  initial begin
    vif.per_frame_vsync = 1'b0;
    vif.per_frame_href  = 1'b0;
    vif.per_frame_clken = 1'b0;
    vif.per_frame_data  = 16'h0;
    test_reset();
    test_colours();
    test_pixels();
    test_full_frame();
    test_line_err();
    test_status_stable();
    test_same_edge();
    test_saturate();
    test_random_frames();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
